// File: rtl/mult_dot_accum.sv
// Dot-product accumulator fed by a free-running multiplier output register.
// Sums a programmed count of unsigned products and hands the result off on valid/ready.
module mult_dot_accum #(
   parameter int N     = 8,
   parameter int LEN_W = 8,
   parameter int GUARD = 8,
   localparam int ACC_W = 2*N + GUARD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [2*N-1:0]   p_in,
   input  logic             p_valid,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             busy,
   output logic             ovf,
   output logic             drop_err
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic             handshake;
   logic             take_start;
   logic [ACC_W:0]   sum_p0;

   // Top bit of the result is the carry out of the accumulator width.
   function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                               input logic [2*N-1:0]   b);
      return {1'b0, a} + {{(GUARD+1){1'b0}}, b};
   endfunction

   assign handshake  = (state == DONE) && acc_ready;
   assign take_start = start && ((state == IDLE) || handshake);
   assign sum_p0     = add_wrap(acc_out, p_in);
   assign acc_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   // Single accumulate stage: product absorbed on the edge it is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_out  <= '0;
         ovf      <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         if (take_start) begin
            acc_out  <= '0;
            ovf      <= 1'b0;
            drop_err <= 1'b0;
            cnt      <= len;
            state    <= (len != '0) ? ACCUM : DONE;
         end else begin
            case (state)
               ACCUM: begin
                  if (p_valid) begin
                     acc_out <= sum_p0[ACC_W-1:0];
                     if (sum_p0[ACC_W]) ovf <= 1'b1;
                     cnt <= cnt - LEN_W'(1);
                     if (cnt == LEN_W'(1)) state <= DONE;
                  end
               end
               DONE: begin
                  if (handshake) state <= IDLE;
               end
               default: ;
            endcase
         end
         // Placed last so a drop in the start cycle survives the clear.
         if (p_valid && (state != ACCUM)) drop_err <= 1'b1;
      end
   end

endmodule

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Downstream consumer of the registered multiplier output stage. It accumulates a programmed number of unsigned products into a wide dot-product sum.
- Presents the finished sum on a valid/ready output handshake.
- The upstream multiplier has no backpressure. Products that arrive while the block cannot use them are dropped and flagged.

Parameters:
- N, 8, operand width of the upstream multiplier; the product input is 2N bits.
- LEN_W, 8, width of the product-count field len.
- GUARD, 8, extra accumulator bits above 2N; ACC_W = 2N+GUARD.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only as defined below.
- len  input  LEN_W  number of products to accumulate; sampled with an accepted start.
- p_in  input  2N  unsigned product from the multiplier output register.
- p_valid  input  1  p_in is a new product this cycle.
- acc_out  output  ACC_W  registered accumulated sum.
- acc_valid  output  1  acc_out is a finished result.
- acc_ready  input  1  consumer accepts the result.
- busy  output  1  state is not IDLE.
- ovf  output  1  sticky: accumulator carried out of ACC_W in the current job.
- drop_err  output  1  sticky: a p_valid product was ignored.

Behaviour:
- Single clock domain, clk; asynchronous active-low reset rst_n.
- Reset (async assert, takes effect immediately, including mid-job):
  - state=IDLE, acc=0, cnt=0.
  - acc_out=0, acc_valid=0, busy=0, ovf=0, drop_err=0.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- States: IDLE, ACCUM, DONE.
- Start acceptance: start is accepted in IDLE, or in DONE on the same cycle as an output handshake (acc_valid & acc_ready).
  - Start is ignored in ACCUM, and ignored in DONE without a handshake.
- Accepted start: acc<=0, ovf<=0, drop_err<=0, cnt<=len.
  - len!=0: next state ACCUM.
  - len==0: next state DONE, so acc_valid=1 with acc_out=0 the next cycle.
- ACCUM with p_valid=1:
  - acc <= (acc + zero-extended p_in) mod 2^ACC_W.
  - Carry out of bit ACC_W-1 sets ovf.
  - cnt <= cnt-1.
  - When cnt==1: next state DONE.
- ACCUM with p_valid=0: hold everything. Gaps of any length are allowed.
- Latency: acc_valid rises on the clock edge that absorbs the final product, i.e. it is high in the cycle after the final p_valid.
- DONE:
  - acc_valid=1; acc_out and ovf are stable until the handshake.
  - A handshake with no start: next state IDLE, acc_valid=0 next cycle. acc_out keeps its value until the next accepted start clears it.
- p_valid in IDLE or DONE: the product is discarded, acc is unchanged, and drop_err is set.
  - drop_err is cleared only by an accepted start or by reset.
  - If p_valid coincides with an accepted start, the product is discarded and drop_err is set in the new job, since set takes priority over clear.
- Simultaneous handshake + start + len!=0 in DONE: the next cycle is ACCUM with acc=0 and acc_valid=0. No idle bubble.
- busy = (state != IDLE).
- All arithmetic is unsigned. There is no saturation; wrap plus ovf is the defined overflow behaviour.

Test Plan:
- Basic job: reset, then start with len=3. Feed p_in=6, 15, 56 on consecutive cycles with acc_ready=1.
  - acc_valid high for exactly 1 cycle, one cycle after the last product, with acc_out=77, ovf=0.
  - busy low the cycle after the handshake.
- Gaps and backpressure: len=2, products 100 and 200 with 3 idle cycles between them, acc_ready=0 for 5 cycles after done.
  - acc_valid and acc_out=300 held constant throughout; the handshake returns the block to IDLE.
- Zero length: start with len=0.
  - Next cycle acc_valid=1, acc_out=0; no products consumed.
- Overflow (LEN_W=9): len=259, every p_in=65025.
  - Final acc_out=64259 (16841475 mod 2^24), ovf=1.
  - The next job clears ovf.
- Drops:
  - p_valid=1 with p_in=9 while in DONE: drop_err=1, acc_out unchanged.
  - p_valid in IDLE: drop_err stays 1.
  - Next accepted start: drop_err=0.
- Back-to-back and reset:
  - Handshake and start (len=1) in the same cycle: next cycle ACCUM, acc_valid=0, and the product is accumulated correctly.
  - rst_n low mid-ACCUM: all outputs 0 immediately; after release the block is in IDLE and ignores further products except for setting drop_err.
